// File: rtl/tick_scheduler.sv
// Frame-tick prescaler plus rotation/wall/spawn event channels with run/pause sequencing.
// Define SPAWN_JITTER_EN to add LFSR jitter (0..3 extra frames) to the spawn interval.
//
// Ports:
//   clk, reset (async, active-low)
//   start, pause   : run control levels
//   cfg_valid/ready, cfg_sel, cfg_period : per-channel period write
//   frame_tick, rot_step, wall_step, spawn_evt : one-cycle registered pulses
//   running        : high in RUN
module tick_scheduler #(
  parameter int CLK_DIV     = 833334,
  parameter int DIV_BITS    = 20,
  parameter int PERIOD_BITS = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   pause,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [1:0]             cfg_sel,
  input  logic [PERIOD_BITS-1:0] cfg_period,
  output logic                   frame_tick,
  output logic                   rot_step,
  output logic                   wall_step,
  output logic                   spawn_evt,
  output logic                   running
);

  localparam int SW = PERIOD_BITS + 1;
  localparam logic [DIV_BITS-1:0] DIV_LAST =
    DIV_BITS'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED
  } state_t;

  state_t state, state_nxt;

  logic [DIV_BITS-1:0]    presc;
  logic                   at_last;
  logic                   adv;
  logic                   tick;
  logic                   acc;
  logic [2:0]             ld;

  logic [PERIOD_BITS-1:0] per [2];
  logic [PERIOD_BITS-1:0] cnt [2];
  logic [1:0]             pls;

  logic [PERIOD_BITS-1:0] sp_per;
  logic [SW-1:0]          sp_cnt;
  logic [SW-1:0]          sp_term;
  logic                   sp_wrap;
  logic                   sp_pls;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start && !pause) state_nxt = RUN;
      RUN:     if (!start)    state_nxt = IDLE;
               else if (pause) state_nxt = PAUSED;
      PAUSED:  if (!start)    state_nxt = IDLE;
               else if (!pause) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  assign running = (state == RUN);
  assign at_last = (presc == DIV_LAST);
  // Only advance when staying in RUN, so no pulse lands
  // in the first PAUSED or IDLE cycle.
  assign adv       = running && start && !pause;
  assign tick      = adv && at_last;
  assign cfg_ready = !(running && at_last);
  assign acc       = cfg_valid && cfg_ready;

  always_comb begin
    ld = '0;
    if (acc) begin
      unique case (1'b1)
        (cfg_sel == 2'd0): ld[0] = 1'b1;
        (cfg_sel == 2'd1): ld[1] = 1'b1;
        (cfg_sel == 2'd2): ld[2] = 1'b1;
        default:           ld    = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc      <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= tick;
      if (state == IDLE)
        presc <= '0;
      else if (adv)
        presc <= at_last ? '0 : presc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        per[i] <= '0;
        cnt[i] <= '0;
      end
      pls <= '0;
    end else begin
      pls <= '0;
      for (int i = 0; i < 2; i++) begin
        if (ld[i]) begin
          per[i] <= cfg_period;
          cnt[i] <= '0;
        end else if (state == IDLE) begin
          cnt[i] <= '0;
        end else if (tick && per[i] != '0) begin
          if (cnt[i] == per[i] - 1'b1) begin
            cnt[i] <= '0;
            pls[i] <= 1'b1;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  assign rot_step  = pls[0];
  assign wall_step = pls[1];

`ifdef SPAWN_JITTER_EN
  logic [7:0]    lfsr;
  logic [7:0]    lfsr_nxt;
  logic [SW-1:0] term_q;

  function automatic logic [SW-1:0] jterm(
    input logic [PERIOD_BITS-1:0] p,
    input logic [1:0]             j
  );
    return {1'b0, p} - SW'(1) + SW'(j);
  endfunction

  assign lfsr_nxt =
    {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr   <= 8'hA5;
      term_q <= '0;
    end else begin
      if (sp_wrap)
        lfsr <= lfsr_nxt;
      if (ld[2])
        term_q <= jterm(cfg_period, lfsr[1:0]);
      else if (sp_wrap)
        term_q <= jterm(sp_per, lfsr_nxt[1:0]);
    end
  end

  assign sp_term = term_q;
`else
  assign sp_term = {1'b0, sp_per} - SW'(1);
`endif

  assign sp_wrap = tick && (sp_per != '0) &&
                   (sp_cnt == sp_term);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_per <= '0;
      sp_cnt <= '0;
      sp_pls <= 1'b0;
    end else begin
      sp_pls <= sp_wrap;
      if (ld[2]) begin
        sp_per <= cfg_period;
        sp_cnt <= '0;
      end else if (state == IDLE) begin
        sp_cnt <= '0;
      end else if (tick && sp_per != '0) begin
        sp_cnt <= sp_wrap ? '0 : sp_cnt + 1'b1;
      end
    end
  end

  assign spawn_evt = sp_pls;

endmodule
